// File: rtl/key_led_sequencer.sv
`default_nettype none
// ============================================================================
// key_led_sequencer : debounced two-key scheduler for a one-hot LED rotation.
// Optional mode: define KEY_LED_PINGPONG_EN for PINGPONG.             Rev 1.0
// ============================================================================
module key_led_sequencer #(
  parameter int LED_W           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TICK_CYCLES     = 12500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_mode,
  input  logic             key_step,
  output logic [LED_W-1:0] led,
  output logic [2:0]       mode,
  output logic             paused
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [DB_W-1:0] C_DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TK_W-1:0] C_TK_LAST = TK_W'(TICK_CYCLES - 1);

  typedef enum logic [2:0] {
    MANUAL   = 3'd0,
    AUTO_L   = 3'd1,
    AUTO_R   = 3'd2,
    BLINK    = 3'd3,
    PINGPONG = 3'd4
  } mode_t;

  logic [1:0] w_keys;
  logic [1:0] w_press;
  logic       w_mode_press;
  logic       w_step_press;

  assign w_keys = {key_step, key_mode};

  generate
    for (genvar i = 0; i < 2; i++) begin : g_key
      logic            r_s1;
      logic            r_s2;
      logic            r_stable;
      logic            r_stable_d;
      logic [DB_W-1:0] r_cnt;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_s1       <= 1'b1;
          r_s2       <= 1'b1;
          r_stable   <= 1'b1;
          r_stable_d <= 1'b1;
          r_cnt      <= '0;
        end else begin
          r_s1       <= w_keys[i];
          r_s2       <= r_s1;
          r_stable_d <= r_stable;
          if (r_s2 == r_stable) begin
            r_cnt <= '0;
          end else if (r_cnt == C_DB_LAST) begin
            r_stable <= r_s2;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + DB_W'(1);
          end
        end
      end

      // Only the 1->0 transition of the accepted level is a press.
      assign w_press[i] = r_stable_d & ~r_stable;
    end
  endgenerate

  assign w_mode_press = w_press[0];
  assign w_step_press = w_press[1];

  mode_t            r_state;
  mode_t            w_next_mode;
  logic [LED_W-1:0] r_pat;
  logic [LED_W-1:0] w_rotl;
  logic [LED_W-1:0] w_rotr;
  logic             r_phase;
  logic             r_paused;
  logic [TK_W-1:0]  r_tick_cnt;
  logic             w_tick;
`ifdef KEY_LED_PINGPONG_EN
  logic             r_dir_right;
`endif

  assign w_tick = (r_tick_cnt == C_TK_LAST);
  assign w_rotl = {r_pat[LED_W-2:0], r_pat[LED_W-1]};
  assign w_rotr = {r_pat[0], r_pat[LED_W-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_cnt <= '0;
    end else if (w_mode_press) begin
      r_tick_cnt <= '0;
    end else if (!r_paused) begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TK_W'(1);
    end
  end

  always_comb begin
    w_next_mode = MANUAL;
    case (r_state)
      MANUAL:   w_next_mode = AUTO_L;
      AUTO_L:   w_next_mode = AUTO_R;
      AUTO_R:   w_next_mode = BLINK;
`ifdef KEY_LED_PINGPONG_EN
      BLINK:    w_next_mode = PINGPONG;
`endif
      default:  w_next_mode = MANUAL;
    endcase
  end

  // Priority: mode press, then step press, then tick (tick dropped on collision).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= MANUAL;
      r_pat       <= LED_W'(1);
      r_phase     <= 1'b1;
      r_paused    <= 1'b0;
`ifdef KEY_LED_PINGPONG_EN
      r_dir_right <= 1'b0;
`endif
    end else if (w_mode_press) begin
      r_state     <= w_next_mode;
      r_phase     <= 1'b1;
      r_paused    <= 1'b0;
`ifdef KEY_LED_PINGPONG_EN
      r_dir_right <= 1'b0;
`endif
    end else if (w_step_press) begin
      if (r_state == MANUAL) r_pat <= w_rotl;
      else                   r_paused <= ~r_paused;
    end else if (w_tick && !r_paused) begin
      case (r_state)
        AUTO_L: r_pat   <= w_rotl;
        AUTO_R: r_pat   <= w_rotr;
        BLINK:  r_phase <= ~r_phase;
`ifdef KEY_LED_PINGPONG_EN
        PINGPONG: begin
          if (r_pat[LED_W-1]) begin
            r_dir_right <= 1'b1;
            r_pat       <= r_pat >> 1;
          end else if (r_pat[0]) begin
            r_dir_right <= 1'b0;
            r_pat       <= r_pat << 1;
          end else if (r_dir_right) begin
            r_pat <= r_pat >> 1;
          end else begin
            r_pat <= r_pat << 1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign led    = ((r_state == BLINK) && !r_phase) ? '0 : r_pat;
  assign mode   = r_state;
  assign paused = r_paused;

endmodule
`default_nettype wire

// File: tb/tb_key_led_sequencer.sv
`default_nettype none
// ============================================================================
// tb_key_led_sequencer : directed self-checking bench, LED_W=4 DB=4 TICK=8.
// Rev 1.0
// ============================================================================
module tb_key_led_sequencer;

  localparam int LED_W = 4;
  localparam int DEB   = 4;
  localparam int TICK  = 8;

  logic             clk      = 1'b0;
  logic             rst      = 1'b1;
  logic             key_mode = 1'b1;
  logic             key_step = 1'b1;
  logic [LED_W-1:0] led;
  logic [2:0]       mode;
  logic             paused;

  int vectors     = 0;
  int miscompares = 0;

  logic [3:0] cp;
  logic [3:0] cp_next;
  logic [2:0] mode_after_blink;

  key_led_sequencer #(
    .LED_W           (LED_W),
    .DEBOUNCE_CYCLES (DEB),
    .TICK_CYCLES     (TICK)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_mode (key_mode),
    .key_step (key_step),
    .led      (led),
    .mode     (mode),
    .paused   (paused)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_led,
                         input logic [2:0] e_mode, input logic e_paused);
    chk({tag, "_led"}, 8'(led), 8'(e_led));
    chk({tag, "_mode"}, 8'(mode), 8'(e_mode));
    chk({tag, "_paused"}, 8'(paused), 8'(e_paused));
  endtask

  task automatic press_step(input string tag, input logic [3:0] e_led);
    key_step = 1'b0;
    cyc(7);
    chk(tag, 8'(led), 8'(e_led));
    key_step = 1'b1;
    cyc(8);
  endtask

  initial begin
`ifdef KEY_LED_PINGPONG_EN
    mode_after_blink = 3'd4;
    cp               = 4'b0010;
    cp_next          = 4'b0100;
`else
    mode_after_blink = 3'd0;
    cp               = 4'b0100;
    cp_next          = 4'b1000;
`endif
    cyc(3);
    chk_all("reset_hold", 4'b0001, 3'd0, 1'b0);
    rst = 1'b0;
    cyc(2);
    chk_all("reset_release", 4'b0001, 3'd0, 1'b0);

    // 3-cycle glitch is shorter than the debounce window
    key_step = 1'b0;
    cyc(3);
    key_step = 1'b1;
    cyc(10);
    chk("glitch_reject", 8'(led), 8'b0001);

    // Held press: register changes exactly 7 edges after the key edge
    key_step = 1'b0;
    cyc(6);
    chk("press_lat_minus1", 8'(led), 8'b0001);
    cyc(1);
    chk("press_lat", 8'(led), 8'b0010);
    cyc(3);
    chk("held_once", 8'(led), 8'b0010);
    key_step = 1'b1;
    cyc(8);
    chk("release_nop", 8'(led), 8'b0010);

    press_step("wrap1", 4'b0100);
    press_step("wrap2", 4'b1000);
    press_step("wrap3", 4'b0001);

    // AUTO_L: mode change lands at relative edge 7, shifts at 15, 23, ...
    key_mode = 1'b0;
    cyc(7);
    chk_all("autol_enter", 4'b0001, 3'd1, 1'b0);
    key_mode = 1'b1;
    cyc(7);
    chk("autol_pre_tick", 8'(led), 8'b0001);
    cyc(1);
    chk("autol_tick1", 8'(led), 8'b0010);
    cyc(8);
    chk("autol_tick2", 8'(led), 8'b0100);

    // Step pulse collides with the tick at edge 31: pause wins, no shift
    cyc(1);
    key_step = 1'b0;
    cyc(7);
    chk_all("pause_on_tick", 4'b0100, 3'd1, 1'b1);
    key_step = 1'b1;
    cyc(20);
    chk("paused_frozen", 8'(led), 8'b0100);

    // Resume at edge 58; counter held at 0, so next shift at 66
    key_step = 1'b0;
    cyc(7);
    chk_all("resume", 4'b0100, 3'd1, 1'b0);
    key_step = 1'b1;
    cyc(7);
    chk("resume_pre_tick", 8'(led), 8'b0100);
    cyc(1);
    chk("resume_tick", 8'(led), 8'b1000);

    // AUTO_R from 1000, first shift 8 edges after the change
    key_mode = 1'b0;
    cyc(7);
    chk_all("autor_enter", 4'b1000, 3'd2, 1'b0);
    key_mode = 1'b1;
    cyc(7);
    chk("autor_pre_tick", 8'(led), 8'b1000);
    cyc(1);
    chk("autor_tick1", 8'(led), 8'b0100);

    // BLINK entered with pat = 0100
    key_mode = 1'b0;
    cyc(6);
    chk_all("autor_hold", 4'b0100, 3'd2, 1'b0);
    cyc(1);
    chk_all("blink_enter", 4'b0100, 3'd3, 1'b0);
    key_mode = 1'b1;
    cyc(7);
    chk("blink_on", 8'(led), 8'b0100);
    cyc(1);
    chk("blink_off", 8'(led), 8'b0000);
    cyc(8);
    chk("blink_on2", 8'(led), 8'b0100);

    key_mode = 1'b0;
    cyc(7);
    chk_all("blink_exit", 4'b0100, mode_after_blink, 1'b0);
    key_mode = 1'b1;

`ifdef KEY_LED_PINGPONG_EN
    cyc(8);
    chk("pp1", 8'(led), 8'b1000);
    cyc(8);
    chk("pp2", 8'(led), 8'b0100);
    cyc(8);
    chk("pp3", 8'(led), 8'b0010);
    cyc(8);
    chk("pp4", 8'(led), 8'b0001);
    cyc(8);
    chk("pp5", 8'(led), 8'b0010);
    key_mode = 1'b0;
    cyc(7);
    chk_all("pp_exit", 4'b0010, 3'd0, 1'b0);
    key_mode = 1'b1;
`endif

    // Simultaneous mode and step in MANUAL: mode advances, step dropped
    cyc(8);
    key_mode = 1'b0;
    key_step = 1'b0;
    cyc(7);
    chk_all("collision", cp, 3'd1, 1'b0);
    key_mode = 1'b1;
    key_step = 1'b1;
    cyc(8);
    chk("collision_autol_tick", 8'(led), 8'(cp_next));

    // Async reset mid-debounce with key_step held low through release
    key_step = 1'b0;
    cyc(3);
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_reset", 4'b0001, 3'd0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(6);
    chk("held_through_reset", 8'(led), 8'b0001);
    cyc(1);
    chk_all("post_reset_press", 4'b0010, 3'd0, 1'b0);
    key_step = 1'b1;
    cyc(8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
